// File: rtl/tt_um_serial_adder_param.sv
// tt_um_serial_adder_param
//   Bit-serial adder/subtractor built around a single full adder. Operands A
//   and B are loaded from ui_in while idle. A start pulse then processes one
//   bit per cycle, LSB first, for WIDTH cycles. The finished sum or difference
//   and the carry flag are published together in the cycle that enters DONE.
//   Subtraction is done as A + ~B + 1, so the carry flag reads as "no borrow".
//   With acc set, the result is written back into A.
//
// Ports
//   clk      : clock; all state updates on the rising edge
//   rst_n    : asynchronous active-low reset
//   ena      : power-good indicator, not used by the logic
//   ui_in    : operand data, bits [WIDTH-1:0]
//   uio_in   : [0] load_a, [1] load_b, [2] start, [3] sub, [4] acc
//   uo_out   : last completed result, zero above WIDTH
//   uio_out  : [7] carry flag, [6] busy, [5] done, [4:0] zero
//   uio_oe   : constant 8'hE0 (upper three uio pins are outputs)
//
// States
//   state | meaning
//   IDLE  | accept operand loads and start
//   RUN   | one bit per cycle through the full adder, WIDTH cycles
//   DONE  | single-cycle done pulse, result already visible

module tt_um_serial_adder_param #(
  parameter int WIDTH = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] LP_LAST = 3'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_r;
  logic             r_c;
  logic             r_cf;
  logic [2:0]       r_cnt;
  logic             r_sub;
  logic             r_acc;

  logic             w_load_a;
  logic             w_load_b;
  logic             w_start;
  logic             w_sub_in;
  logic             w_acc_in;
  logic [7:0]       w_a_ext;
  logic [7:0]       w_b_ext;
  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_sum;
  logic             w_c_next;
  logic [WIDTH-1:0] w_s_next;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic             w_unused;

  assign w_load_a = uio_in[0];
  assign w_load_b = uio_in[1];
  assign w_start  = uio_in[2];
  assign w_sub_in = uio_in[3];
  assign w_acc_in = uio_in[4];

  // Operands are widened to 8 bits so the 3-bit counter indexes them
  // exactly for every legal WIDTH.
  assign w_a_ext  = 8'(r_a);
  assign w_b_ext  = 8'(r_b);
  assign w_a_bit  = w_a_ext[r_cnt];
  assign w_b_bit  = w_b_ext[r_cnt] ^ r_sub;
  assign w_sum    = w_a_bit ^ w_b_bit ^ r_c;
  assign w_c_next = (w_a_bit & w_b_bit) | (w_a_bit & r_c) | (w_b_bit & r_c);
  assign w_last   = (r_cnt == LP_LAST);

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  always_comb begin
    w_s_next = r_s >> 1;
    w_s_next[WIDTH-1] = w_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_r     <= '0;
      r_c     <= 1'b0;
      r_cf    <= 1'b0;
      r_cnt   <= 3'd0;
      r_sub   <= 1'b0;
      r_acc   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load_a) r_a <= ui_in[WIDTH-1:0];
          if (w_load_b) r_b <= ui_in[WIDTH-1:0];
          // A load in the same cycle as start takes priority.
          if (w_start && !w_load_a && !w_load_b) begin
            r_sub   <= w_sub_in;
            r_acc   <= w_acc_in;
            r_cnt   <= 3'd0;
            r_c     <= w_sub_in;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_s   <= w_s_next;
          r_c   <= w_c_next;
          r_cnt <= r_cnt + 3'd1;
          if (w_last) begin
            r_state <= ST_DONE;
            r_r     <= w_s_next;
            r_cf    <= w_c_next;
            if (r_acc) r_a <= w_s_next;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_busy  = (r_state == ST_RUN);
  assign w_done  = (r_state == ST_DONE);

  assign uo_out  = 8'(r_r);
  assign uio_out = {r_cf, w_busy, w_done, 5'b0_0000};
  assign uio_oe  = 8'hE0;

  assign w_unused = &{1'b0, ena, ui_in, uio_in[7:5]};

endmodule
